// File: rtl/tlb_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tlb_op_scheduler
// Purpose  : Arbitrates the TLB s1 port and TLB write/read/invalidate controls
//            between EXE lookups and WB maintenance ops. Optional macro:
//            TLBFILL_LFSR_EN (LFSR-based TLBFILL victim instead of counter).
// Revision : 1.0 - initial release
// ============================================================================
module tlb_op_scheduler #(
   parameter int TLBNUM = 16,
   parameter int IDXW   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            exe_req_valid,
   input  logic [18:0]     exe_req_vppn,
   input  logic            exe_req_va_bit12,
   output logic            exe_req_ready,
   input  logic            op_valid,
   input  logic [2:0]      op_type,
   input  logic [4:0]      op_inv_op,
   input  logic [9:0]      op_rj_asid,
   input  logic [31:0]     op_rk_va,
   output logic            op_ready,
   output logic            op_done,
   output logic            op_hit,
   output logic [IDXW-1:0] op_index,
   input  logic [9:0]      csr_asid,
   input  logic [18:0]     csr_ehi_vppn,
   input  logic [IDXW-1:0] csr_idx_index,
   output logic [18:0]     s1_vppn,
   output logic            s1_va_bit12,
   output logic [9:0]      s1_asid,
   input  logic            s1_found,
   input  logic [IDXW-1:0] s1_index,
   output logic            tlb_we,
   output logic [IDXW-1:0] tlb_w_index,
   output logic [IDXW-1:0] tlb_r_index,
   output logic            tlbrd_we,
   output logic            tlb_inv_valid,
   output logic [4:0]      tlb_inv_op
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   state_t            state_q, state_d;
   logic [2:0]        type_q;
   logic [4:0]        inv_op_q;
   logic [9:0]        rj_asid_q;
   logic [19:0]       rk_va_q;   // rk_va[31:12]; low bits never reach the TLB
   logic              hit_q, hit_d;
   logic [IDXW-1:0]   hidx_q, hidx_d;
   logic [IDXW-1:0]   fill_idx;
   logic              unused_rk_low;

   assign unused_rk_low = ^op_rk_va[11:0];
   assign op_hit        = hit_q;
   assign op_index      = hidx_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         type_q    <= '0;
         inv_op_q  <= '0;
         rj_asid_q <= '0;
         rk_va_q   <= '0;
         hit_q     <= 1'b0;
         hidx_q    <= '0;
      end else begin
         state_q <= state_d;
         hit_q   <= hit_d;
         hidx_q  <= hidx_d;
         if (op_ready) begin
            type_q    <= op_type;
            inv_op_q  <= op_inv_op;
            rj_asid_q <= op_rj_asid;
            rk_va_q   <= op_rk_va[31:12];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      op_ready      = 1'b0;
      exe_req_ready = 1'b0;
      op_done       = 1'b0;
      tlb_we        = 1'b0;
      tlb_w_index   = '0;
      tlb_r_index   = '0;
      tlbrd_we      = 1'b0;
      tlb_inv_valid = 1'b0;
      tlb_inv_op    = '0;
      s1_vppn       = exe_req_vppn;
      s1_va_bit12   = exe_req_va_bit12;
      s1_asid       = csr_asid;
      hit_d         = hit_q;
      hidx_d        = hidx_q;
      // Reset gating keeps the reset cycle free of pulses even mid-op.
      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               op_ready      = op_valid & ~flush & (op_type <= OP_INV);
               exe_req_ready = exe_req_valid & ~op_valid;
               if (op_ready) state_d = ST_EXEC;
            end
            ST_EXEC: begin
               state_d = flush ? ST_IDLE : ST_DONE;
               case (type_q)
                  OP_SRCH: begin
                     s1_vppn     = csr_ehi_vppn;
                     s1_va_bit12 = 1'b0;
                     hit_d       = s1_found;
                     hidx_d      = s1_index;
                  end
                  OP_RD: begin
                     tlb_r_index = csr_idx_index;
                     tlbrd_we    = 1'b1;
                  end
                  OP_WR: begin
                     tlb_we      = 1'b1;
                     tlb_w_index = csr_idx_index;
                  end
                  OP_FILL: begin
                     tlb_we      = 1'b1;
                     tlb_w_index = fill_idx;
                  end
                  OP_INV: begin
                     tlb_inv_valid = 1'b1;
                     tlb_inv_op    = inv_op_q;
                     if (inv_op_q == 5'd4 || inv_op_q == 5'd5 || inv_op_q == 5'd6)
                        s1_asid = rj_asid_q;
                     if (inv_op_q == 5'd5 || inv_op_q == 5'd6) begin
                        s1_vppn     = rk_va_q[19:1];
                        s1_va_bit12 = rk_va_q[0];
                     end
                  end
                  default: ;
               endcase
            end
            ST_DONE: begin
               op_done = ~flush;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef TLBFILL_LFSR_EN
   // Fibonacci LFSR x^5+x^3+1, free-running.
   logic [4:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= 5'b00001;
      else       lfsr_q <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
   end

   assign fill_idx = lfsr_q[IDXW-1:0];
`else
   logic [IDXW-1:0] fill_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_cnt_q <= '0;
      end else if (state_q == ST_EXEC && type_q == OP_FILL) begin
         fill_cnt_q <= (fill_cnt_q == IDXW'(TLBNUM - 1)) ? '0 : fill_cnt_q + 1'b1;
      end
   end

   assign fill_idx = fill_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_op_scheduler
// Purpose  : Vector table plus scoreboard bench for tlb_op_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_op_scheduler;

   localparam logic [9:0]  C_CSR_ASID = 10'h155;
   localparam logic [18:0] C_EXE_VPPN = 19'h7ABCD;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        exe_req_valid, exe_req_va_bit12, exe_req_ready;
   logic [18:0] exe_req_vppn;
   logic        op_valid, op_ready, op_done, op_hit;
   logic [2:0]  op_type;
   logic [4:0]  op_inv_op;
   logic [9:0]  op_rj_asid;
   logic [31:0] op_rk_va;
   logic [3:0]  op_index;
   logic [9:0]  csr_asid;
   logic [18:0] csr_ehi_vppn;
   logic [3:0]  csr_idx_index;
   logic [18:0] s1_vppn;
   logic        s1_va_bit12;
   logic [9:0]  s1_asid;
   logic        s1_found;
   logic [3:0]  s1_index;
   logic        tlb_we, tlbrd_we, tlb_inv_valid;
   logic [3:0]  tlb_w_index, tlb_r_index;
   logic [4:0]  tlb_inv_op;

   always #5 clk = ~clk;

   tlb_op_scheduler #(.TLBNUM(16), .IDXW(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .exe_req_valid(exe_req_valid), .exe_req_vppn(exe_req_vppn),
      .exe_req_va_bit12(exe_req_va_bit12), .exe_req_ready(exe_req_ready),
      .op_valid(op_valid), .op_type(op_type), .op_inv_op(op_inv_op),
      .op_rj_asid(op_rj_asid), .op_rk_va(op_rk_va), .op_ready(op_ready),
      .op_done(op_done), .op_hit(op_hit), .op_index(op_index),
      .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn), .csr_idx_index(csr_idx_index),
      .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index),
      .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_r_index(tlb_r_index),
      .tlbrd_we(tlbrd_we), .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op)
   );

   typedef struct {
      logic [2:0]  typ;
      logic [4:0]  inv_op;
      logic [9:0]  rj;
      logic [31:0] rk;
      logic [18:0] ehi;
      logic [3:0]  idx;
      logic        found;
      logic [3:0]  sidx;
      logic        e_we;
      logic [3:0]  e_widx;
      logic        e_rd;
      logic [3:0]  e_ridx;
      logic        e_inv;
      logic [4:0]  e_invop;
      logic [9:0]  e_asid;
      logic [18:0] e_vppn;
      logic        e_b12;
      logic        e_hit;
      logic [3:0]  e_hidx;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Defaults describe an op whose EXEC cycle leaves s1 on the EXE source.
   function automatic vec_t base(input logic [2:0] typ, input logic hit, input logic [3:0] hidx);
      vec_t v;
      v.typ = typ; v.inv_op = 5'd0; v.rj = 10'd0; v.rk = 32'd0; v.ehi = 19'd0;
      v.idx = 4'd0; v.found = 1'b0; v.sidx = 4'd0;
      v.e_we = 1'b0; v.e_widx = 4'd0; v.e_rd = 1'b0; v.e_ridx = 4'd0;
      v.e_inv = 1'b0; v.e_invop = 5'd0;
      v.e_asid = C_CSR_ASID; v.e_vppn = C_EXE_VPPN; v.e_b12 = 1'b1;
      v.e_hit = hit; v.e_hidx = hidx;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      vec_t e;
      @(negedge clk);
      op_valid = 1'b1; op_type = v.typ; op_inv_op = v.inv_op; op_rj_asid = v.rj;
      op_rk_va = v.rk; csr_ehi_vppn = v.ehi; csr_idx_index = v.idx;
      s1_found = v.found; s1_index = v.sidx;
      sb.push_back(v);
      #1;
      chk("accept op_ready", op_ready, 1);
      chk("accept exe_ready", exe_req_ready, 0);
      chk("accept tlb_we", tlb_we, 0);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("exec tlb_we", tlb_we, v.e_we);
      chk("exec w_index", tlb_w_index, v.e_widx);
      chk("exec tlbrd_we", tlbrd_we, v.e_rd);
      chk("exec r_index", tlb_r_index, v.e_ridx);
      chk("exec inv_valid", tlb_inv_valid, v.e_inv);
      chk("exec inv_op", tlb_inv_op, v.e_invop);
      chk("exec s1_asid", s1_asid, v.e_asid);
      chk("exec s1_vppn", s1_vppn, v.e_vppn);
      chk("exec s1_bit12", s1_va_bit12, v.e_b12);
      chk("exec op_done", op_done, 0);
      chk("exec exe_ready", exe_req_ready, 0);
      @(negedge clk);
      #1;
      chk("done exe_ready", exe_req_ready, 0);
      chk("done tlb_we", tlb_we, 0);
      chk("done op_done", op_done, 1);
      e = sb.pop_front();
      chk("done op_hit", op_hit, e.e_hit);
      chk("done op_index", op_index, e.e_hidx);
      @(negedge clk);
      #1;
      chk("idle exe_ready", exe_req_ready, 1);
      chk("idle op_done", op_done, 0);
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; flush = 1'b0;
      exe_req_valid = 1'b1; exe_req_vppn = C_EXE_VPPN; exe_req_va_bit12 = 1'b1;
      op_valid = 1'b0; op_type = 3'd0; op_inv_op = 5'd0; op_rj_asid = 10'd0; op_rk_va = 32'd0;
      csr_asid = C_CSR_ASID; csr_ehi_vppn = 19'd0; csr_idx_index = 4'd0;
      s1_found = 1'b0; s1_index = 4'd0;

      v = base(3'd0, 1'b1, 4'd7); v.ehi = 19'h12345; v.found = 1'b1; v.sidx = 4'd7;
      v.e_vppn = 19'h12345; v.e_b12 = 1'b0; tbl.push_back(v);
      v = base(3'd2, 1'b1, 4'd7); v.idx = 4'hA; v.e_we = 1'b1; v.e_widx = 4'hA; tbl.push_back(v);
      v = base(3'd1, 1'b1, 4'd7); v.idx = 4'h5; v.e_rd = 1'b1; v.e_ridx = 4'h5; tbl.push_back(v);
      v = base(3'd4, 1'b1, 4'd7); v.inv_op = 5'd5; v.rj = 10'h03A; v.rk = 32'h0040_3000;
      v.e_inv = 1'b1; v.e_invop = 5'd5; v.e_asid = 10'h03A; v.e_vppn = 19'h00201; v.e_b12 = 1'b1;
      tbl.push_back(v);
      v = base(3'd4, 1'b1, 4'd7); v.inv_op = 5'd4; v.rj = 10'h2C5; v.rk = 32'h1234_5000;
      v.e_inv = 1'b1; v.e_invop = 5'd4; v.e_asid = 10'h2C5; tbl.push_back(v);
      v = base(3'd4, 1'b1, 4'd7); v.inv_op = 5'd2; v.rj = 10'h011; v.rk = 32'hFFFF_F000;
      v.e_inv = 1'b1; v.e_invop = 5'd2; tbl.push_back(v);
      v = base(3'd0, 1'b0, 4'd3); v.ehi = 19'h00F0F; v.found = 1'b0; v.sidx = 4'd3;
      v.e_vppn = 19'h00F0F; v.e_b12 = 1'b0; tbl.push_back(v);
      v = base(3'd4, 1'b0, 4'd3); v.inv_op = 5'd6; v.rj = 10'h3FF; v.rk = 32'hFFFF_E000;
      v.e_inv = 1'b1; v.e_invop = 5'd6; v.e_asid = 10'h3FF; v.e_vppn = 19'h7FFFF; v.e_b12 = 1'b0;
      tbl.push_back(v);
      for (int i = 0; i < 17; i++) begin
         v = base(3'd3, 1'b0, 4'd3); v.idx = 4'hC; v.e_we = 1'b1; v.e_widx = 4'(i % 16);
         tbl.push_back(v);
      end

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst op_ready", op_ready, 0);
      chk("rst exe_ready", exe_req_ready, 0);
      chk("rst op_done", op_done, 0);
      chk("rst op_hit", op_hit, 0);
      chk("rst op_index", op_index, 0);
      chk("rst tlb_we", tlb_we, 0);
      chk("rst tlbrd_we", tlbrd_we, 0);
      chk("rst inv_valid", tlb_inv_valid, 0);
      chk("rst s1_vppn", s1_vppn, C_EXE_VPPN);
      chk("rst s1_asid", s1_asid, C_CSR_ASID);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("idle exe_ready after rst", exe_req_ready, 1);

      // Reserved op types are never accepted
      @(negedge clk);
      op_valid = 1'b1; op_type = 3'd5;
      #1;
      chk("reserved5 op_ready", op_ready, 0);
      @(negedge clk);
      op_type = 3'd7;
      #1;
      chk("reserved7 op_ready", op_ready, 0);
      chk("reserved tlb_we", tlb_we, 0);
      chk("reserved tlbrd_we", tlbrd_we, 0);
      chk("reserved inv_valid", tlb_inv_valid, 0);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("reserved no op_done", op_done, 0);
      chk("reserved still idle", exe_req_ready, 1);

      foreach (tbl[i]) run_vec(tbl[i]);

      // Flush in IDLE blocks accept
      @(negedge clk);
      op_valid = 1'b1; op_type = 3'd2; csr_idx_index = 4'h6; flush = 1'b1;
      #1;
      chk("flush idle op_ready", op_ready, 0);
      @(negedge clk);
      op_valid = 1'b0; flush = 1'b0;
      #1;
      chk("flush idle no tlb_we", tlb_we, 0);

      // Flush in EXEC of a RD
      @(negedge clk);
      op_valid = 1'b1; op_type = 3'd1; csr_idx_index = 4'h9;
      #1;
      chk("flushexec op_ready", op_ready, 1);
      @(negedge clk);
      op_valid = 1'b0; flush = 1'b1;
      #1;
      chk("flushexec tlbrd_we", tlbrd_we, 1);
      chk("flushexec r_index", tlb_r_index, 4'h9);
      chk("flushexec op_done", op_done, 0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flushexec next op_done", op_done, 0);
      chk("flushexec next idle", exe_req_ready, 1);
      chk("flushexec next tlbrd_we", tlbrd_we, 0);

      // Flush in DONE of an INV
      @(negedge clk);
      op_valid = 1'b1; op_type = 3'd4; op_inv_op = 5'd1;
      #1;
      chk("flushdone op_ready", op_ready, 1);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("flushdone inv_valid", tlb_inv_valid, 1);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flushdone op_done", op_done, 0);
      chk("flushdone inv not repeated", tlb_inv_valid, 0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flushdone idle", exe_req_ready, 1);

      // Reset in DONE, then a FILL that must restart at index 0
      @(negedge clk);
      op_valid = 1'b1; op_type = 3'd2; csr_idx_index = 4'h2;
      #1;
      chk("rstmid op_ready", op_ready, 1);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("rstmid tlb_we", tlb_we, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rstmid op_done", op_done, 0);
      chk("rstmid tlb_we off", tlb_we, 0);
      chk("rstmid exe_ready", exe_req_ready, 0);
      @(negedge clk);
      reset = 1'b0; op_valid = 1'b1; op_type = 3'd3;
      #1;
      chk("postrst op_ready", op_ready, 1);
      chk("postrst op_hit", op_hit, 0);
      chk("postrst op_index", op_index, 0);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("postrst fill tlb_we", tlb_we, 1);
      chk("postrst fill w_index", tlb_w_index, 0);
      @(negedge clk);
      #1;
      chk("postrst op_done", op_done, 1);
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
